// File: rtl/exa_cfg_ctrl_pkg.sv
// Shared types and parameter defaults for the EXA configuration sequencer.
package exa_cfg_ctrl_pkg;

  localparam int unsigned EXA_ADDR_WIDTH    = 5;
  localparam int unsigned EXA_MEM_WIDTH     = 32;
  localparam int unsigned EXA_SETTLE_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_UNCFG  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } exa_state_e;

  // Counter width able to hold SETTLE_CYCLES-1 (at least one bit).
  function automatic int unsigned settle_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/exa_cfg_ctrl_if.sv
// Host-side configuration bus of exa_cfg_ctrl: burst command plus valid/ready parameter stream.
interface exa_cfg_ctrl_if
  import exa_cfg_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = EXA_ADDR_WIDTH,
  parameter int unsigned MEM_WIDTH  = EXA_MEM_WIDTH
) ();

  logic                  Start_SI;
  logic [ADDR_WIDTH-1:0] BaseAddr_DI;
  logic [ADDR_WIDTH:0]   Len_DI;
  logic                  Abort_SI;
  logic                  CfgValid_SI;
  logic [MEM_WIDTH-1:0]  CfgData_DI;
  logic                  CfgReady_SO;

  modport master (
    output Start_SI, BaseAddr_DI, Len_DI, Abort_SI, CfgValid_SI, CfgData_DI,
    input  CfgReady_SO
  );

  modport slave (
    input  Start_SI, BaseAddr_DI, Len_DI, Abort_SI, CfgValid_SI, CfgData_DI,
    output CfgReady_SO
  );

endinterface

// File: rtl/exa_cfg_ctrl_settle_timer.sv
// Loadable down-counter with zero flag; times the EXA settle window after the last write.
module exa_cfg_ctrl_settle_timer
  import exa_cfg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = settle_width(EXA_SETTLE_CYCLES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exa_cfg_ctrl.sv
// Configuration sequencer for the EXA datapath: bursts parameter words into EXA and gates ExaEn.
// Optional feature macro EXA_CFG_CHECKSUM_EN adds Checksum_DO (sum of words of the current burst).
module exa_cfg_ctrl
  import exa_cfg_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = EXA_ADDR_WIDTH,
  parameter int unsigned MEM_WIDTH     = EXA_MEM_WIDTH,
  parameter int unsigned SETTLE_CYCLES = EXA_SETTLE_CYCLES
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  exa_cfg_ctrl_if.slave         cfg,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
  output logic                  ExaEn_SO,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic                  Err_SO
`ifdef EXA_CFG_CHECKSUM_EN
  ,
  output logic [MEM_WIDTH-1:0]  Checksum_DO
`endif
);

  localparam int unsigned         SETTLE_W    = settle_width(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH       = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE     = (ADDR_WIDTH + 1)'(1);

  exa_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  cfg_ready_q;
  logic                  wren_q;
  logic [ADDR_WIDTH-1:0] addr_out_q;
  logic [MEM_WIDTH-1:0]  par_q;
  logic                  exaen_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic cmd_idle;
  logic len_ok;
  logic start_ok;
  logic beat;
  logic last_beat;
  logic settle_zero;

  always_comb begin
    cmd_idle  = (state_q == ST_UNCFG) || (state_q == ST_RUN);
    len_ok    = (cfg.Len_DI != '0) && (cfg.Len_DI <= DEPTH);
    start_ok  = cmd_idle && cfg.Start_SI && len_ok;
    // A beat coincident with Abort is dropped, so it never reaches EXA or the checksum.
    beat      = (state_q == ST_LOAD) && cfg_ready_q && cfg.CfgValid_SI && !cfg.Abort_SI;
    last_beat = (remain_q == LEN_ONE);
  end

  exa_cfg_ctrl_settle_timer #(
    .WIDTH (SETTLE_W)
  ) u_settle_timer (
    .clk_i      (Clk_CI),
    .rst_i      (Rst_RI),
    .load_i     (beat && last_beat),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (state_q == ST_SETTLE),
    .zero_o     (settle_zero)
  );

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q     <= ST_UNCFG;
      addr_q      <= '0;
      remain_q    <= '0;
      cfg_ready_q <= 1'b0;
      wren_q      <= 1'b0;
      addr_out_q  <= '0;
      par_q       <= '0;
      exaen_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_UNCFG, ST_RUN: begin
          if (cfg.Start_SI) begin
            if (len_ok) begin
              state_q     <= ST_LOAD;
              addr_q      <= cfg.BaseAddr_DI;
              remain_q    <= cfg.Len_DI;
              cfg_ready_q <= 1'b1;
              busy_q      <= 1'b1;
              exaen_q     <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (cfg.Abort_SI) begin
            state_q     <= ST_UNCFG;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b1;
          end else begin
            err_q <= cfg.Start_SI;
            if (beat) begin
              wren_q     <= 1'b1;
              addr_out_q <= addr_q;
              par_q      <= cfg.CfgData_DI;
              addr_q     <= addr_q + 1'b1;
              remain_q   <= remain_q - 1'b1;
              if (last_beat) begin
                state_q     <= ST_SETTLE;
                cfg_ready_q <= 1'b0;
              end
            end
          end
        end
        ST_SETTLE: begin
          if (cfg.Abort_SI) begin
            state_q <= ST_UNCFG;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            err_q <= cfg.Start_SI;
            if (settle_zero) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              exaen_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_UNCFG;
      endcase
    end
  end

`ifdef EXA_CFG_CHECKSUM_EN
  logic [MEM_WIDTH-1:0] sum_q;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (beat) begin
      sum_q <= sum_q + cfg.CfgData_DI;
    end
  end

  assign Checksum_DO = sum_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

  assign cfg.CfgReady_SO = cfg_ready_q;
  assign WrEn_SO         = wren_q;
  assign Addr_DO         = addr_out_q;
  assign PAR_Out_DO      = par_q;
  assign ExaEn_SO        = exaen_q;
  assign Busy_SO         = busy_q;
  assign Done_SO         = done_q;
  assign Err_SO          = err_q;

endmodule

// File: tb/tb_exa_cfg_ctrl.sv
// Self-checking bench for exa_cfg_ctrl; honours EXA_CFG_CHECKSUM_EN when defined.
module tb_exa_cfg_ctrl;
  import exa_cfg_ctrl_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned MW = 32;
  localparam int unsigned SC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wren;
  logic [AW-1:0] addr;
  logic [MW-1:0] par;
  logic          exaen;
  logic          busy;
  logic          done;
  logic          err;
`ifdef EXA_CFG_CHECKSUM_EN
  logic [MW-1:0] csum;
  logic [MW-1:0] exp_sum;
`endif

  exa_cfg_ctrl_if #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW)) cfg ();

  exa_cfg_ctrl #(
    .ADDR_WIDTH    (AW),
    .MEM_WIDTH     (MW),
    .SETTLE_CYCLES (SC)
  ) dut (
    .Clk_CI      (clk),
    .Rst_RI      (rst),
    .cfg         (cfg),
    .WrEn_SO     (wren),
    .Addr_DO     (addr),
    .PAR_Out_DO  (par),
    .ExaEn_SO    (exaen),
    .Busy_SO     (busy),
    .Done_SO     (done),
    .Err_SO      (err)
`ifdef EXA_CFG_CHECKSUM_EN
    ,
    .Checksum_DO (csum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [MW-1:0] d;
  } wr_t;

  typedef struct {
    int          base;
    int          len;
    bit          toggle;
    int          abort_at;
    logic [31:0] d0;
    logic [31:0] dstep;
  } row_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  n_done = 0;
  int  n_err = 0;
  int  done_cyc = 0;
  int  last_wr_cyc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // One clock: inputs set before the call are applied at the posedge, outputs sampled at negedge.
  task automatic step();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (wren === 1'b1) begin
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=addr %0d data %0h required=no write", addr, par);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(addr), 64'(e.a));
        check("wr_data", 64'(par), 64'(e.d));
      end
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err === 1'b1) n_err++;
  endtask

  task automatic push_wr(input int a, input logic [MW-1:0] d);
    wr_t e;
    e.a = AW'(a);
    e.d = d;
    exp_q.push_back(e);
`ifdef EXA_CFG_CHECKSUM_EN
    exp_sum = exp_sum + d;
`endif
  endtask

  task automatic start_cmd(input int base, input int len);
    cfg.Start_SI    = 1'b1;
    cfg.BaseAddr_DI = AW'(base);
    cfg.Len_DI      = (AW + 1)'(len);
`ifdef EXA_CFG_CHECKSUM_EN
    exp_sum = '0;
`endif
    step();
    cfg.Start_SI = 1'b0;
  endtask

  task automatic finish_settle();
    int g = 0;
    int d0 = n_done;
    while (n_done == d0 && g < 20) begin
      step();
      g++;
    end
    check("done_seen", 64'(n_done - d0), 64'd1);
    check("done_latency", 64'(done_cyc - last_wr_cyc), 64'(SC));
    check("run_exaen", 64'(exaen), 64'd1);
    check("run_busy", 64'(busy), 64'd0);
`ifdef EXA_CFG_CHECKSUM_EN
    check("checksum", 64'(csum), 64'(exp_sum));
`endif
    step();
    check("done_pulse", 64'(done), 64'd0);
    check("exaen_hold", 64'(exaen), 64'd1);
  endtask

  task automatic run_row(input row_t r);
    int   beats = 0;
    int   k = 0;
    int   guard = 0;
    int   err0 = n_err;
    bit   valid;
    bit   aborted = 1'b0;
    logic [MW-1:0] d = r.d0;
    start_cmd(r.base, r.len);
    check("start_ready", 64'(cfg.CfgReady_SO), 64'd1);
    check("start_exaen", 64'(exaen), 64'd0);
    check("start_busy", 64'(busy), 64'd1);
    while (beats < r.len && guard < 200) begin
      guard++;
      valid = !r.toggle || (k % 2 == 0);
      k++;
      check("beat_ready", 64'(cfg.CfgReady_SO), 64'd1);
      cfg.CfgValid_SI = valid;
      cfg.CfgData_DI  = d;
      if (valid && beats == r.abort_at) begin
        cfg.Abort_SI = 1'b1;
        aborted = 1'b1;
      end else if (valid) begin
        push_wr(r.base + beats, d);
      end
      step();
      cfg.CfgValid_SI = 1'b0;
      cfg.Abort_SI    = 1'b0;
      if (valid) begin
        beats++;
        d = d + r.dstep;
      end
      if (aborted) break;
    end
    if (aborted) begin
      check("abort_err", 64'(n_err - err0), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ready", 64'(cfg.CfgReady_SO), 64'd0);
      check("abort_exaen", 64'(exaen), 64'd0);
      step();
      check("abort_err_pulse", 64'(err), 64'd0);
    end else begin
      check("last_ready_low", 64'(cfg.CfgReady_SO), 64'd0);
      check("settle_busy", 64'(busy), 64'd1);
      finish_settle();
      check("row_no_err", 64'(n_err - err0), 64'd0);
    end
    check("writes_consumed", 64'(exp_q.size()), 64'd0);
  endtask

  row_t rows[6];
  int   bad_len[3];

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int d0;

    rows[0] = '{4,  3,  1'b0, -1, 32'h0000_000A, 32'h1};
    rows[1] = '{30, 4,  1'b1, -1, 32'h0000_0100, 32'h10};
    rows[2] = '{0,  8,  1'b0,  2, 32'h0000_0055, 32'h1};
    rows[3] = '{10, 2,  1'b0, -1, 32'hFFFF_FFFF, 32'h3};
    rows[4] = '{17, 32, 1'b1, -1, 32'h0000_1000, 32'h7};
    rows[5] = '{31, 1,  1'b0, -1, 32'h0000_DEAD, 32'h1};
    bad_len[0] = 0;
    bad_len[1] = 33;
    bad_len[2] = 63;

    rst             = 1'b1;
    cfg.Start_SI    = 1'b0;
    cfg.BaseAddr_DI = '0;
    cfg.Len_DI      = '0;
    cfg.Abort_SI    = 1'b0;
    cfg.CfgValid_SI = 1'b0;
    cfg.CfgData_DI  = '0;
`ifdef EXA_CFG_CHECKSUM_EN
    exp_sum = '0;
`endif
    repeat (3) step();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_par", 64'(par), 64'd0);
`ifdef EXA_CFG_CHECKSUM_EN
    check("rst_checksum", 64'(csum), 64'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_exaen", 64'(exaen), 64'd0);
      check("idle_ready", 64'(cfg.CfgReady_SO), 64'd0);
      check("idle_wren", 64'(wren), 64'd0);
    end

    // Illegal length while unconfigured.
    e0 = n_err;
    start_cmd(3, 0);
    check("uncfg_badlen_err", 64'(n_err - e0), 64'd1);
    check("uncfg_badlen_busy", 64'(busy), 64'd0);
    check("uncfg_badlen_exaen", 64'(exaen), 64'd0);

    for (int i = 0; i < 6; i++) run_row(rows[i]);

    // Illegal lengths while running: Err pulse, ExaEn stays up.
    for (int i = 0; i < 3; i++) begin
      e0 = n_err;
      start_cmd(5, bad_len[i]);
      check("run_badlen_err", 64'(n_err - e0), 64'd1);
      check("run_badlen_exaen", 64'(exaen), 64'd1);
      check("run_badlen_busy", 64'(busy), 64'd0);
      step();
      check("run_badlen_pulse", 64'(err), 64'd0);
    end

    // Start together with Abort in RUN: Start wins.
    e0 = n_err;
    cfg.Abort_SI = 1'b1;
    start_cmd(3, 1);
    cfg.Abort_SI = 1'b0;
    check("startabort_busy", 64'(busy), 64'd1);
    check("startabort_exaen", 64'(exaen), 64'd0);
    check("startabort_noerr", 64'(n_err - e0), 64'd0);
    cfg.CfgValid_SI = 1'b1;
    cfg.CfgData_DI  = 32'h77;
    push_wr(3, 32'h77);
    step();
    cfg.CfgValid_SI = 1'b0;
    finish_settle();

    // Start during LOAD and SETTLE is rejected; burst carries on at its own addresses.
    e0 = n_err;
    start_cmd(8, 2);
    cfg.Start_SI    = 1'b1;
    cfg.BaseAddr_DI = AW'(20);
    cfg.Len_DI      = (AW + 1)'(5);
    cfg.CfgValid_SI = 1'b1;
    cfg.CfgData_DI  = 32'h11;
    push_wr(8, 32'h11);
    step();
    cfg.Start_SI = 1'b0;
    check("load_start_err", 64'(n_err - e0), 64'd1);
    check("load_start_ready", 64'(cfg.CfgReady_SO), 64'd1);
    cfg.CfgData_DI = 32'h22;
    push_wr(9, 32'h22);
    step();
    cfg.CfgValid_SI = 1'b0;
    check("load_last_ready", 64'(cfg.CfgReady_SO), 64'd0);
    cfg.Start_SI = 1'b1;
    step();
    cfg.Start_SI = 1'b0;
    check("settle_start_err", 64'(n_err - e0), 64'd2);
    finish_settle();

    // Reset during SETTLE: back to UNCFG, no Done.
    start_cmd(0, 1);
    cfg.CfgValid_SI = 1'b1;
    cfg.CfgData_DI  = 32'h5;
    push_wr(0, 32'h5);
    step();
    cfg.CfgValid_SI = 1'b0;
    check("pre_rst_settle_busy", 64'(busy), 64'd1);
    d0  = n_done;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_settle_busy", 64'(busy), 64'd0);
    check("rst_settle_exaen", 64'(exaen), 64'd0);
    check("rst_settle_ready", 64'(cfg.CfgReady_SO), 64'd0);
    repeat (5) step();
    check("rst_settle_nodone", 64'(n_done - d0), 64'd0);
    check("rst_settle_exaen_low", 64'(exaen), 64'd0);

    // Reset mid-burst with a coincident beat: that beat is never written.
    start_cmd(0, 4);
    cfg.CfgValid_SI = 1'b1;
    cfg.CfgData_DI  = 32'h1;
    push_wr(0, 32'h1);
    step();
    cfg.CfgData_DI = 32'h2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cfg.CfgValid_SI = 1'b0;
    check("rst_load_busy", 64'(busy), 64'd0);
    check("rst_load_ready", 64'(cfg.CfgReady_SO), 64'd0);
    repeat (2) step();
    check("rst_load_writes", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
